bbox_scan: RTL



---
 rtl/bbox_if.sv | 31 +++
 rtl/bbox_scan.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/bbox_if.sv
// Handshake, threshold and frame-buffer read bundle between the main FSM, the
// frame buffer and bbox_scan.
interface bbox_if #(
    parameter int ADDR_W = 17,
    parameter int PIX_W  = 12
);
    logic              start;
    logic              ack;
    logic [3:0]        r_min;
    logic [3:0]        g_max;
    logic [3:0]        b_max;
    logic [ADDR_W-1:0] rd_addr;
    logic [PIX_W-1:0]  rd_data;
    logic              busy;
    logic              done;
    logic              found;
    logic [8:0]        x_min;
    logic [8:0]        x_max;
    logic [8:0]        y_min;
    logic [8:0]        y_max;

    modport master (
        output start, ack, r_min, g_max, b_max, rd_data,
        input  rd_addr, busy, done, found, x_min, x_max, y_min, y_max
    );

    modport slave (
        input  start, ack, r_min, g_max, b_max, rd_data,
        output rd_addr, busy, done, found, x_min, x_max, y_min, y_max
    );
endinterface

// File: rtl/bbox_scan.sv
// Scans a whole frame through the buffer read port and reports the bounding box
// of pixels passing the RGB444 colour thresholds, via a start/done/ack handshake.
module bbox_scan #(
    parameter int H_RES      = 320,
    parameter int V_RES      = 240,
    parameter int ADDR_W     = 17,
    parameter int PIX_W      = 12,
    parameter int RD_LATENCY = 1
) (
    input  logic  clk,
    input  logic  reset,
    bbox_if.slave bus
);
    localparam int                N         = H_RES * V_RES;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);
    localparam logic [8:0]        X_LAST    = 9'(H_RES - 1);
    localparam int                DW        = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

    // PUBLISH is the cycle after the last pixel has been folded into the accumulators
    typedef enum logic [2:0] {IDLE, SCAN, DRAIN, PUBLISH, DONE, RELEASE} state_t;

    state_t                       state_q, state_d;
    logic [ADDR_W-1:0]            rd_addr_q, rd_addr_d;
    logic [8:0]                   x_q, x_d, y_q, y_d;
    logic [11:0]                  thr_q, thr_d;
    logic [DW-1:0]                drain_q, drain_d;
    logic [RD_LATENCY:1]          vld_pipe_q, vld_pipe_d;
    logic [RD_LATENCY:1][8:0]     xp_q, xp_d, yp_q, yp_d;
    logic                         acc_hit_q, acc_hit_d;
    logic [8:0]                   acc_xmin_q, acc_xmin_d, acc_xmax_q, acc_xmax_d;
    logic [8:0]                   acc_ymin_q, acc_ymin_d, acc_ymax_q, acc_ymax_d;
    logic                         found_q, found_d;
    logic [8:0]                   xmin_q, xmin_d, xmax_q, xmax_d;
    logic [8:0]                   ymin_q, ymin_d, ymax_q, ymax_d;
    logic                         clr, pub, hit;
    logic [8:0]                   px, py;

    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        x_d       = x_q;
        y_d       = y_q;
        thr_d     = thr_q;
        drain_d   = drain_q;
        clr       = 1'b0;
        pub       = 1'b0;
        case (state_q)
            IDLE: begin
                rd_addr_d = '0;
                if (bus.start) begin
                    state_d = SCAN;
                    thr_d   = {bus.r_min, bus.g_max, bus.b_max};
                    x_d     = '0;
                    y_d     = '0;
                    clr     = 1'b1;
                end
            end
            SCAN: begin
                if (rd_addr_q == LAST_ADDR) begin
                    state_d = DRAIN;
                    drain_d = '0;
                end else begin
                    rd_addr_d = rd_addr_q + 1'b1;
                    if (x_q == X_LAST) begin
                        x_d = '0;
                        y_d = y_q + 9'd1;
                    end else begin
                        x_d = x_q + 9'd1;
                    end
                end
            end
            DRAIN: begin
                if (drain_q == DW'(RD_LATENCY - 1)) state_d = PUBLISH;
                else drain_d = drain_q + 1'b1;
            end
            PUBLISH: begin
                pub     = 1'b1;
                state_d = DONE;
            end
            DONE: if (bus.ack) state_d = RELEASE;
            RELEASE: begin
                if (!bus.ack) begin
                    state_d   = IDLE;
                    rd_addr_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Coordinates ride alongside the read so they meet their pixel data
    always_comb begin
        vld_pipe_d    = '0;
        xp_d          = '0;
        yp_d          = '0;
        vld_pipe_d[1] = (state_q == SCAN);
        xp_d[1]       = x_q;
        yp_d[1]       = y_q;
        for (int i = 2; i <= RD_LATENCY; i++) begin
            vld_pipe_d[i] = vld_pipe_q[i-1];
            xp_d[i]       = xp_q[i-1];
            yp_d[i]       = yp_q[i-1];
        end
    end

    assign px  = xp_q[RD_LATENCY];
    assign py  = yp_q[RD_LATENCY];
    assign hit = (bus.rd_data[11:8] >= thr_q[11:8]) &&
                 (bus.rd_data[7:4]  <= thr_q[7:4])  &&
                 (bus.rd_data[3:0]  <= thr_q[3:0]);

    always_comb begin
        acc_hit_d  = acc_hit_q;
        acc_xmin_d = acc_xmin_q;
        acc_xmax_d = acc_xmax_q;
        acc_ymin_d = acc_ymin_q;
        acc_ymax_d = acc_ymax_q;
        if (clr) begin
            acc_hit_d  = 1'b0;
            acc_xmin_d = '0;
            acc_xmax_d = '0;
            acc_ymin_d = '0;
            acc_ymax_d = '0;
        end else if (vld_pipe_q[RD_LATENCY] && hit) begin
            acc_hit_d = 1'b1;
            if (!acc_hit_q) begin
                acc_xmin_d = px;
                acc_xmax_d = px;
                acc_ymin_d = py;
                acc_ymax_d = py;
            end else begin
                if (px < acc_xmin_q) acc_xmin_d = px;
                if (px > acc_xmax_q) acc_xmax_d = px;
                if (py < acc_ymin_q) acc_ymin_d = py;
                if (py > acc_ymax_q) acc_ymax_d = py;
            end
        end
    end

    always_comb begin
        found_d = found_q;
        xmin_d  = xmin_q;
        xmax_d  = xmax_q;
        ymin_d  = ymin_q;
        ymax_d  = ymax_q;
        if (pub) begin
            found_d = acc_hit_q;
            xmin_d  = acc_xmin_q;
            xmax_d  = acc_xmax_q;
            ymin_d  = acc_ymin_q;
            ymax_d  = acc_ymax_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            rd_addr_q  <= '0;
            x_q        <= '0;
            y_q        <= '0;
            thr_q      <= '0;
            drain_q    <= '0;
            vld_pipe_q <= '0;
            xp_q       <= '0;
            yp_q       <= '0;
            acc_hit_q  <= 1'b0;
            acc_xmin_q <= '0;
            acc_xmax_q <= '0;
            acc_ymin_q <= '0;
            acc_ymax_q <= '0;
            found_q    <= 1'b0;
            xmin_q     <= '0;
            xmax_q     <= '0;
            ymin_q     <= '0;
            ymax_q     <= '0;
        end else begin
            state_q    <= state_d;
            rd_addr_q  <= rd_addr_d;
            x_q        <= x_d;
            y_q        <= y_d;
            thr_q      <= thr_d;
            drain_q    <= drain_d;
            vld_pipe_q <= vld_pipe_d;
            xp_q       <= xp_d;
            yp_q       <= yp_d;
            acc_hit_q  <= acc_hit_d;
            acc_xmin_q <= acc_xmin_d;
            acc_xmax_q <= acc_xmax_d;
            acc_ymin_q <= acc_ymin_d;
            acc_ymax_q <= acc_ymax_d;
            found_q    <= found_d;
            xmin_q     <= xmin_d;
            xmax_q     <= xmax_d;
            ymin_q     <= ymin_d;
            ymax_q     <= ymax_d;
        end
    end

    assign bus.rd_addr = rd_addr_q;
    assign bus.busy    = (state_q == SCAN) || (state_q == DRAIN);
    assign bus.done    = (state_q == DONE);
    assign bus.found   = found_q;
    assign bus.x_min   = xmin_q;
    assign bus.x_max   = xmax_q;
    assign bus.y_min   = ymin_q;
    assign bus.y_max   = ymax_q;
endmodule
